booth_mult_seq: RTL and testbench

- Iterative radix-4 Booth multiplier.
- Each cycle it recodes DIGITS_PER_CYCLE multiplier digit triplets into partial products and accumulates them.
- Operand width, throughput-per-cycle and signed/unsigned mode are configurable per instance or per operation.
- Sits in the FP multiply path, taking significands and returning the full-width product to normalisation, with valid/ready handshakes on both sides.

---
 rtl/booth_pkg.sv | 34 +++
 rtl/booth_pp_gen.sv | 26 ++
 rtl/booth_mult_seq.sv | 124 ++++++++++++
 tb/tb_booth_mult_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: size helpers,
// digit encodings, recoding function and the control FSM states.
package booth_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Booth digit values: 0, +M, +2M, -M, -2M.
  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

  // Number of radix-4 digits needed to cover a WIDTH-bit operand in either mode.
  function automatic int calc_ndig(input int width);
    return width / 2 + 1;
  endfunction

  // CALC cycles needed to retire ndig digits at dpc digits per cycle.
  function automatic int calc_cyc(input int ndig, input int dpc);
    return (ndig + dpc - 1) / dpc;
  endfunction

  // Map a triplet {b(2i+1), b(2i), b(2i-1)} to its Booth digit.
  function automatic booth_digit_t recode(input logic [2:0] code);
    booth_digit_t d;
    case (code)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator for one radix-4 Booth digit.
// The multiplicand arrives already extended to WIDTH+2 bits, which is
// enough headroom for +/-2M in both signed and unsigned modes.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic [2:0]              code,
  input  logic [WIDTH+1:0]        mcand_ext,
  output logic signed [WIDTH+1:0] pp
);

  // Select 0, +M, +2M, -M or -2M from the recoded triplet.
  always_comb begin
    pp = '0;
    case (recode(code))
      P1:      pp = mcand_ext;
      P2:      pp = {mcand_ext[WIDTH:0], 1'b0};
      M1:      pp = -mcand_ext;
      M2:      pp = -{mcand_ext[WIDTH:0], 1'b0};
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides.
// The multiplier is held in a shift register that drops 2*DIGITS_PER_CYCLE
// bits per CALC cycle; digits past the top of the operand read as sign or
// zero bits and therefore recode to 0, so no per-digit masking is needed.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH            = 25,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NDIG   = calc_ndig(WIDTH);
  localparam int CYC    = calc_cyc(NDIG, DIGITS_PER_CYCLE);
  localparam int MW     = 2 * CYC * DIGITS_PER_CYCLE + 1;  // shifter incl. implicit 0
  localparam int MW_EXT = MW - 1 - WIDTH;
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int CNT_W  = $clog2(CYC + 1);

  state_t                 state_reg, state_next;
  logic [ACC_W-1:0]       acc_reg, acc_next, pp_sum;
  logic [CNT_W-1:0]       cnt_reg;
  logic [MW-1:0]          mplier_reg;
  logic [WIDTH+1:0]       mcand_reg;
  logic [2*WIDTH-1:0]     product_reg;
  logic                   calc_done;
  logic                   accept;

  logic signed [WIDTH+1:0] pp   [DIGITS_PER_CYCLE];
  logic [ACC_W-1:0]        term [DIGITS_PER_CYCLE];

  assign calc_done = (cnt_reg == CNT_W'(CYC));
  assign accept    = (state_reg == IDLE) && in_valid && !flush;
  assign product   = product_reg;

  // One partial-product generator per digit retired each cycle, each
  // sign-extended to accumulator width and placed at its in-cycle weight.
  generate
    for (genvar gi = 0; gi < DIGITS_PER_CYCLE; gi++) begin : g_pp
      booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
        .code      (mplier_reg[2*gi+2 -: 3]),
        .mcand_ext (mcand_reg),
        .pp        (pp[gi])
      );
      assign term[gi] = {{WIDTH{pp[gi][WIDTH+1]}}, pp[gi]} << (2 * gi);
    end
  endgenerate

  // Sum this cycle's partial products and add them at the current digit offset.
  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      pp_sum = pp_sum + term[j];
    end
    acc_next = acc_reg + (pp_sum << (32'(cnt_reg) * 2 * DIGITS_PER_CYCLE));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (calc_done) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: operand capture, accumulation and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      mplier_reg  <= '0;
      mcand_reg   <= '0;
      product_reg <= '0;
    end else if (flush) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mplier_reg <= {{MW_EXT{is_signed & mplier[WIDTH-1]}}, mplier, 1'b0};
      mcand_reg  <= {{2{is_signed & mcand[WIDTH-1]}}, mcand};
    end else if (state_reg == CALC) begin
      if (calc_done) begin
        product_reg <= acc_reg[2*WIDTH-1:0];
      end else begin
        acc_reg    <= acc_next;
        cnt_reg    <= cnt_reg + 1'b1;
        mplier_reg <= mplier_reg >> (2 * DIGITS_PER_CYCLE);
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: three instances (1, 4 and 13 digits
// per cycle) checked for product, latency, backpressure, flush and reset.
module tb_booth_mult_seq;

  localparam int W  = 25;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic          is_signed [3];
  logic [W-1:0]  mcand     [3];
  logic [W-1:0]  mplier    [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [PW-1:0] product   [3];

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(1)) u_dpc1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .is_signed(is_signed[0]),
    .mcand(mcand[0]), .mplier(mplier[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0])
  );

  booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(4)) u_dpc4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .is_signed(is_signed[1]),
    .mcand(mcand[1]), .mplier(mplier[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1])
  );

  booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(13)) u_dpc13 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .is_signed(is_signed[2]),
    .mcand(mcand[2]), .mplier(mplier[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .product(product[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product via native 64-bit multiply.
  function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({39'd0, a});
    sb = s ? longint'($signed(b)) : longint'({39'd0, b});
    return PW'(sa * sb);
  endfunction

  // One full transaction: accept, wait for out_valid, check, drain.
  task automatic run_op(input int u, input string tag, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [PW-1:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(in_ready[u]), 64'd1);
    is_signed[u] = s;
    mcand[u]     = a;
    mplier[u]    = b;
    in_valid[u]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[u]  = 1'b0;
    mcand[u]     = ~a;
    mplier[u]    = ~b;
    is_signed[u] = ~s;
    cyc = 0;
    while (!out_valid[u] && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_prod"}, 64'(product[u]), 64'(exp));
    $display("op inst=%0d %s s=%0d %h x %h -> %h (lat %0d)", u, tag, s, a, b, product[u], cyc);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid[u]), 64'd0);
  endtask

  initial begin
    int seen;
    int cyc;
    logic [W-1:0] ra, rb;
    logic         rs;

    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      is_signed[i] = 1'b0;
      mcand[i]     = '0;
      mplier[i]    = '0;
      out_ready[i] = 1'b0;
    end
    flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_product", 64'(product[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Directed vectors, 1 digit per cycle: 13 CALC cycles + 1 => latency 14.
    run_op(0, "s3x5",     1'b1, 25'd3,       25'd5,       50'd15,              14);
    run_op(0, "sm1xm1",   1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 50'd1,               14);
    run_op(0, "umaxsq",   1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001,   14);
    run_op(0, "smin2",    1'b1, 25'h1000000, 25'h1000000, 50'h1000000000000,   14);
    run_op(0, "sminxmax", 1'b1, 25'h1000000, 25'h0FFFFFF, 50'h3000001000000,   14);
    run_op(0, "sm1x3",    1'b1, 25'h1FFFFFF, 25'd3,       50'h3FFFFFFFFFFFD,   14);
    run_op(0, "umaxx3",   1'b0, 25'h1FFFFFF, 25'd3,       50'h5FFFFFD,         14);

    // Backpressure: product held, new operands ignored while in DONE.
    @(negedge clk);
    is_signed[0] = 1'b1; mcand[0] = 25'd9; mplier[0] = 25'd9; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    cyc = 0;
    while (!out_valid[0] && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_lat", 64'(cyc), 64'd14);
    in_valid[0] = 1'b1; mcand[0] = 25'd3; mplier[0] = 25'd3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_prod", 64'(product[0]), 64'd81);
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
    end
    $display("op inst=0 backpressure 9 x 9 -> %h held 10 cycles", product[0]);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("bp_release_ov", 64'(out_valid[0]), 64'd0);
    chk("bp_release_rdy", 64'(in_ready[0]), 64'd1);
    run_op(0, "s7xm6", 1'b1, 25'd7, 25'h1FFFFFA, 50'h3FFFFFFFFFFD6, 14);

    // Flush on the fifth CALC cycle.
    @(negedge clk);
    is_signed[0] = 1'b1; mcand[0] = 25'd3; mplier[0] = 25'd5; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_rdy", 64'(in_ready[0]), 64'd1);
    chk("flush_ov", 64'(out_valid[0]), 64'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    $display("op inst=0 flush during CALC, out_valid seen %0d times", seen);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    is_signed[0] = 1'b1; mcand[0] = 25'd6; mplier[0] = 25'd7; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", 64'(in_ready[0]), 64'd1);
    chk("arst_ov", 64'(out_valid[0]), 64'd0);
    chk("arst_prod", 64'(product[0]), 64'd0);
    $display("op inst=0 reset mid-CALC, product now %h", product[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(0, "post_rst_2x2", 1'b1, 25'd2, 25'd2, 50'd4, 14);

    // 4 digits per cycle: 4 CALC cycles => latency 5.
    run_op(1, "d4_sm1xm1", 1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 50'd1,             5);
    run_op(1, "d4_umaxsq", 1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001, 5);
    run_op(1, "d4_s7xm6",  1'b1, 25'd7,       25'h1FFFFFA, 50'h3FFFFFFFFFFD6, 5);
    // 13 digits per cycle: 1 CALC cycle => latency 2.
    run_op(2, "d13_smin2",    1'b1, 25'h1000000, 25'h1000000, 50'h1000000000000, 2);
    run_op(2, "d13_sminxmax", 1'b1, 25'h1000000, 25'h0FFFFFF, 50'h3000001000000, 2);
    run_op(2, "d13_umaxsq",   1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001, 2);

    // Random operands against the reference multiply.
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'(k % 2);
      run_op(1, "d4_rand", rs, ra, rb, ref_mul(rs, ra, rb), 5);
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(2, "d13_rand", rs, ra, rb, ref_mul(rs, ra, rb), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
